// File: rtl/trap_csr_ctrl.sv
// rtl/trap_csr_ctrl.sv - trap commit controller owning mepc/mcause/mtval/mstatus and the IFU redirect
module trap_csr_ctrl #(
    parameter int XLEN     = 32,
    parameter int PC_SIZE  = 32,
    parameter int NUM_EXCP = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dbg_mode,
    input  logic [NUM_EXCP-1:0]      excp_vld,
    input  logic [NUM_EXCP*4-1:0]    excp_code,
    input  logic [NUM_EXCP*XLEN-1:0] excp_tval,
    input  logic                     irq_vld,
    input  logic [3:0]               irq_code,
    input  logic                     mret_req,
    input  logic [PC_SIZE-1:0]       trap_pc,
    input  logic [XLEN-1:0]          mtvec,
    input  logic                     csr_wr_en,
    input  logic [1:0]               csr_wr_sel,
    input  logic [XLEN-1:0]          csr_wr_data,
    output logic [PC_SIZE-1:0]       mepc_o,
    output logic [XLEN-1:0]          mcause_o,
    output logic [XLEN-1:0]          mtval_o,
    output logic [XLEN-1:0]          mstatus_o,
    output logic                     trap_ack,
    output logic                     flush_req,
    output logic [PC_SIZE-1:0]       flush_pc,
    input  logic                     flush_ack
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t               state;
    logic [PC_SIZE-1:0]   mepc;
    logic [XLEN-1:0]      mcause;
    logic [XLEN-1:0]      mtval;
    logic                 mie;
    logic                 mpie;

    logic                 excp_any;
    logic [3:0]           sel_code;
    logic [XLEN-1:0]      sel_tval;
    logic                 irq_take;
    logic                 commit;
    logic [PC_SIZE-1:0]   vec_base;
    logic [PC_SIZE-1:0]   irq_target;

    // Scan from the highest index down so the lowest pending index wins.
    always_comb begin
        excp_any = 1'b0;
        sel_code = 4'h0;
        sel_tval = '0;
        for (int i = NUM_EXCP - 1; i >= 0; i--) begin
            if (excp_vld[i]) begin
                excp_any = 1'b1;
                sel_code = excp_code[4*i +: 4];
                sel_tval = excp_tval[XLEN*i +: XLEN];
            end
        end
    end

    assign irq_take   = irq_vld && mie;
    assign commit     = (state == IDLE) && !dbg_mode && (excp_any || irq_take || mret_req);
    assign vec_base   = {mtvec[PC_SIZE-1:2], 2'b00};
    assign irq_target = mtvec[0] ? vec_base + {{(PC_SIZE-6){1'b0}}, irq_code, 2'b00} : vec_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mepc      <= '0;
            mcause    <= '0;
            mtval     <= '0;
            mie       <= 1'b0;
            mpie      <= 1'b0;
            trap_ack  <= 1'b0;
            flush_req <= 1'b0;
            flush_pc  <= '0;
        end else begin
            trap_ack <= commit;
            if (commit) begin
                state     <= FLUSH;
                flush_req <= 1'b1;
                if (excp_any) begin
                    mepc     <= {trap_pc[PC_SIZE-1:1], 1'b0};
                    mcause   <= {{(XLEN-4){1'b0}}, sel_code};
                    mtval    <= sel_tval;
                    mpie     <= mie;
                    mie      <= 1'b0;
                    flush_pc <= vec_base;
                end else if (irq_take) begin
                    mepc     <= {trap_pc[PC_SIZE-1:1], 1'b0};
                    mcause   <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
                    mtval    <= '0;
                    mpie     <= mie;
                    mie      <= 1'b0;
                    flush_pc <= irq_target;
                end else begin
                    mie      <= mpie;
                    mpie     <= 1'b1;
                    flush_pc <= mepc;
                end
            end else begin
                // Software writes lose to a commit on the same edge.
                if (csr_wr_en) begin
                    case (csr_wr_sel)
                        2'b00: mepc   <= {csr_wr_data[PC_SIZE-1:1], 1'b0};
                        2'b01: mcause <= csr_wr_data;
                        2'b10: mtval  <= csr_wr_data;
                        default: begin
                            mie  <= csr_wr_data[3];
                            mpie <= csr_wr_data[7];
                        end
                    endcase
                end
                if (state == FLUSH && flush_ack) begin
                    state     <= IDLE;
                    flush_req <= 1'b0;
                end
            end
        end
    end

    assign mepc_o    = mepc;
    assign mcause_o  = mcause;
    assign mtval_o   = mtval;
    assign mstatus_o = {{(XLEN-8){1'b0}}, mpie, 3'b000, mie, 3'b000};

endmodule
